// File: rtl/arp_frame_tx.sv
// ---------------------------------------------------------------------------
// arp_frame_tx
// Serialises one Ethernet II + ARP frame (request or reply) MSB-first onto an
// 8-bit AXI-Stream master. The FCS is left to the MAC.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   arp_tx_start         level request from the arbiter, held until done seen
//   arp_oper             1 = request (opcode 1), 0 = reply (opcode 2)
//   local_mac/local_ip   own addresses (SHA/SPA, Ethernet source)
//   target_mac/target_ip peer addresses (THA/TPA; MAC ignored for requests)
//   m_axis_*             8-bit AXI-Stream master towards the MAC TX path
//   arp_data_tx_done     frame fully accepted; held until arp_tx_start low
//   tx_busy              high while sending or waiting for start to drop
// ---------------------------------------------------------------------------
module arp_frame_tx #(
   parameter bit PAD_TO_MIN = 1'b1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        arp_tx_start,
   input  logic        arp_oper,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   input  logic [47:0] target_mac,
   input  logic [31:0] target_ip,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        arp_data_tx_done,
   output logic        tx_busy
);

   localparam logic [5:0] LAST_IDX = PAD_TO_MIN ? 6'd59 : 6'd41;

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [5:0]  cnt_nxt;
   logic        oper_q;
   logic [47:0] lmac_q;
   logic [31:0] lip_q;
   logic [47:0] tmac_q;
   logic [31:0] tip_q;

   assign cnt_nxt = cnt_q + 6'd1;

   // Byte at offset idx of the frame; anything past the ARP body is padding.
   function automatic logic [7:0] frame_byte(input logic [5:0]  idx,
                                             input logic        oper,
                                             input logic [47:0] smac,
                                             input logic [31:0] sip,
                                             input logic [47:0] tmac,
                                             input logic [31:0] tip);
      logic [47:0]  dest;
      logic [47:0]  tha;
      logic [335:0] hdr;
      logic [335:0] sh;
      dest = oper ? 48'hFFFF_FFFF_FFFF : tmac;
      tha  = oper ? 48'h0 : tmac;
      hdr  = {dest, smac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
              8'h00, (oper ? 8'h01 : 8'h02), smac, sip, tha, tip};
      sh   = '0;
      frame_byte = 8'h00;
      if (idx < 6'd42) begin
         // Shift the wanted byte down to the bottom: offset 41 is the LSB.
         sh = hdr >> {(6'd41 - idx), 3'b000};
         frame_byte = sh[7:0];
      end
   endfunction

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         oper_q           <= 1'b0;
         lmac_q           <= '0;
         lip_q            <= '0;
         tmac_q           <= '0;
         tip_q            <= '0;
         m_axis_tdata     <= '0;
         m_axis_tvalid    <= 1'b0;
         m_axis_tlast     <= 1'b0;
         arp_data_tx_done <= 1'b0;
         tx_busy          <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arp_tx_start) begin
                  state_q       <= StSend;
                  cnt_q         <= '0;
                  oper_q        <= arp_oper;
                  lmac_q        <= local_mac;
                  lip_q         <= local_ip;
                  tmac_q        <= target_mac;
                  tip_q         <= target_ip;
                  // Byte 0 comes straight from the inputs being latched now.
                  m_axis_tdata  <= frame_byte(6'd0, arp_oper, local_mac, local_ip,
                                              target_mac, target_ip);
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
                  tx_busy       <= 1'b1;
               end
            end
            StSend: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (m_axis_tlast) begin
                     state_q          <= StDone;
                     m_axis_tvalid    <= 1'b0;
                     m_axis_tlast     <= 1'b0;
                     arp_data_tx_done <= 1'b1;
                  end else begin
                     cnt_q        <= cnt_nxt;
                     m_axis_tdata <= frame_byte(cnt_nxt, oper_q, lmac_q, lip_q,
                                                tmac_q, tip_q);
                     m_axis_tlast <= (cnt_nxt == LAST_IDX);
                  end
               end
            end
            StDone: begin
               // Leaving only on a low start prevents a resend from a held level.
               if (!arp_tx_start) begin
                  state_q          <= StIdle;
                  arp_data_tx_done <= 1'b0;
                  tx_busy          <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/arp_frame_tx.md
Name: arp_frame_tx

Overview:
Downstream ARP transmit stage fed by the ARP operation arbiter. On arp_tx_start it latches the operation select and the address fields. It then serialises one complete Ethernet II + ARP frame, MSB-first, onto an 8-bit AXI-Stream master towards the MAC TX path. It signals completion back to the arbiter with arp_data_tx_done. FCS is not generated; the MAC appends it.

Parameters:
PAD_TO_MIN, 1, 1: frame padded with 0x00 to 60 bytes (tlast on byte 59); 0: frame ends at byte 41 (tlast on byte 41).

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
arp_tx_start  input  1  level request from arbiter; held high until done is seen
arp_oper  input  1  1 = request (opcode 0x0001), 0 = reply (opcode 0x0002); valid while arp_tx_start high
local_mac  input  48  own MAC (SHA, Ethernet source)
local_ip  input  32  own IPv4 (SPA)
target_mac  input  48  peer MAC (reply: Ethernet dest and THA; ignored for request)
target_ip  input  32  peer IPv4 (TPA)
m_axis_tdata  output  8  frame byte
m_axis_tvalid  output  1  byte valid
m_axis_tready  input  1  sink ready
m_axis_tlast  output  1  last byte of frame
arp_data_tx_done  output  1  frame fully accepted; held until arp_tx_start low
tx_busy  output  1  high in SEND and DONE

Behaviour:
- Reset (async assert, sync release): state IDLE, byte counter 0, m_axis_tvalid/tlast/tdata = 0, arp_data_tx_done = 0, tx_busy = 0. Reset mid-frame aborts immediately; tvalid drops with reset, and no done is issued.
- Registers: all outputs registered; byte counter 6 bits.
- IDLE -> SEND when arp_tx_start = 1.
  - Same edge: latch arp_oper, local_mac, local_ip, target_mac, target_ip.
  - Same edge: counter = 0; tvalid = 1 and byte 0 presented on the next cycle (1-cycle start latency).
- SEND:
  - A beat transfers when tvalid & tready; the counter then advances and the next byte is presented the following cycle.
  - While tvalid & !tready: tdata/tlast held stable and tvalid never deasserted.
  - tlast = 1 only with the final byte (59 or 41).
  - Full throughput is 1 byte/cycle with tready tied high: 60 (or 42) consecutive beats.
  - On the transfer of the tlast byte -> DONE; tvalid = 0 and tlast = 0 next cycle.
- Byte map (offset: content):
  - 0-5: dest MAC (request: FF:FF:FF:FF:FF:FF; reply: target_mac)
  - 6-11: local_mac
  - 12-13: 0x08 0x06
  - 14-15: 0x00 0x01
  - 16-17: 0x08 0x00
  - 18: 0x06
  - 19: 0x04
  - 20-21: 0x00, then 0x01 (request) / 0x02 (reply)
  - 22-27: local_mac
  - 28-31: local_ip
  - 32-37: THA (request: 00:00:00:00:00:00; reply: target_mac)
  - 38-41: target_ip
  - 42-59: 0x00 (PAD_TO_MIN = 1 only)
  - Multi-byte fields are transmitted MSB first (byte 0 = mac[47:40]).
- DONE:
  - arp_data_tx_done = 1, held while arp_tx_start = 1.
  - When arp_tx_start = 0 -> IDLE; done = 0 the next cycle.
  - A new frame therefore needs arp_tx_start to be seen low first, so there is no double send from a level start.
  - Against the arbiter: done rises in cycle N, start falls in N+1, and IDLE is reached at the N+2 edge.
- Ignored events:
  - arp_tx_start deasserted during SEND: ignored; the frame completes and done is asserted. DONE then exits on the first cycle start is low.
  - arp_oper or address inputs changing during SEND/DONE: ignored (latched copies used).
  - arp_tx_start high during SEND/DONE: no effect.
- No timeout: a permanently low tready stalls SEND indefinitely.

Test Plan:
- Request:
  - Stimulus: arp_oper = 1, local_mac = 02:00:00:00:00:01, local_ip = C0A8_0001, target_ip = C0A8_0002, tready = 1.
  - Response: 60 beats starting FF×6, 02 00 00 00 00 01, 08 06 00 01 08 00 06 04 00 01; THA 00×6; TPA C0 A8 00 02; bytes 42-59 = 00; tlast only on beat 59; done one cycle after beat 59.
- Reply:
  - Stimulus: arp_oper = 0, target_mac = 0A:0B:0C:0D:0E:0F.
  - Response: bytes 0-5 and 32-37 = 0A 0B 0C 0D 0E 0F; bytes 20-21 = 00 02.
- Backpressure:
  - Stimulus: random tready, ~50% duty.
  - Response: byte sequence identical to the tready = 1 run; tdata/tlast stable during every stall; exactly 60 transfers.
- Handshake with arbiter model:
  - Stimulus: resp and rq requests pulsed together, then rq again.
  - Response: two frames in order, opcode 0x0002 then 0x0001; done high until start drops; no third frame.
- Reset mid-frame:
  - Stimulus: assert aresetn = 0 at beat 20.
  - Response: tvalid/done/tx_busy = 0 immediately; after release a new start produces a full frame from byte 0.
- PAD_TO_MIN = 0:
  - Stimulus: request frame.
  - Response: 42 beats with tlast on byte 41 (TPA LSB); start held low after done -> IDLE within 2 cycles.
